// File: rtl/blit_addr_seq_if.sv
// rtl/blit_addr_seq_if.sv - memory request and address-unit control bus of the blitter sequencer
interface blit_addr_seq_if;
  logic       mem_req;
  logic       mem_ack;
  logic       gena2;
  logic [1:0] addbsel;
  logic       a1_upd;
  logic       a2_upd;

  modport master (
    output mem_req,
    output gena2,
    output addbsel,
    output a1_upd,
    output a2_upd,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  gena2,
    input  addbsel,
    input  a1_upd,
    input  a2_upd,
    output mem_ack
  );
endinterface

// File: rtl/blit_addr_seq.sv
// rtl/blit_addr_seq.sv - blitter address sequencer: pixel/line loops driving pointer updates and memory requests
module blit_addr_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             go,
  input  logic [CNT_W-1:0] inner_cnt,
  input  logic [CNT_W-1:0] outer_cnt,
  input  logic             srcen,
  input  logic             upda1,
  input  logic             upda2,
  input  logic             stop,
  blit_addr_seq_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] inner_rem,
  output logic [CNT_W-1:0] outer_rem
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SREAD   = 3'd1,
    DWRITE  = 3'd2,
    PIXUPD  = 3'd3,
    LINEUPD = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] inner_sh, outer_sh;
  logic             srcen_sh, upda1_sh, upda2_sh;
  logic [CNT_W-1:0] inner_n, outer_n;
  logic             accept;
  logic             a1_upd_r, a2_upd_r;
  state_t           pix_start;

  assign accept    = (state == IDLE) && go;
  assign pix_start = srcen_sh ? SREAD : DWRITE;

  always_comb begin
    state_n = state;
    inner_n = inner_rem;
    outer_n = outer_rem;
    case (state)
      IDLE: begin
        if (go) begin
          inner_n = inner_cnt;
          outer_n = outer_cnt;
          if (inner_cnt == '0 || outer_cnt == '0) state_n = DONE;
          else                                    state_n = srcen ? SREAD : DWRITE;
        end
      end
      SREAD: begin
        if (stop)             state_n = DONE;
        else if (bus.mem_ack) state_n = DWRITE;
      end
      DWRITE: begin
        if (stop)             state_n = DONE;
        else if (bus.mem_ack) state_n = PIXUPD;
      end
      PIXUPD: begin
        if (stop) begin
          state_n = DONE;
        end else begin
          inner_n = inner_rem - ONE;
          state_n = (inner_rem == ONE) ? LINEUPD : pix_start;
        end
      end
      LINEUPD: begin
        if (stop) begin
          state_n = DONE;
        end else begin
          outer_n = outer_rem - ONE;
          inner_n = inner_sh;
          state_n = (outer_rem == ONE) ? DONE : pix_start;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are stable for the whole state.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state       <= IDLE;
      inner_rem   <= '0;
      outer_rem   <= '0;
      inner_sh    <= '0;
      outer_sh    <= '0;
      srcen_sh    <= 1'b0;
      upda1_sh    <= 1'b0;
      upda2_sh    <= 1'b0;
      bus.mem_req <= 1'b0;
      bus.gena2   <= 1'b0;
      bus.addbsel <= 2'b00;
      a1_upd_r    <= 1'b0;
      a2_upd_r    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= state_n;
      inner_rem <= inner_n;
      outer_rem <= outer_n;
      if (accept) begin
        inner_sh <= inner_cnt;
        outer_sh <= outer_cnt;
        srcen_sh <= srcen;
        upda1_sh <= upda1;
        upda2_sh <= upda2;
      end
      bus.mem_req <= (state_n == SREAD) || (state_n == DWRITE);
      bus.gena2   <= (state_n == SREAD);
      bus.addbsel <= (state_n == LINEUPD) ? 2'b01 : 2'b00;
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      case (state_n)
        PIXUPD: begin
          a1_upd_r <= 1'b1;
          a2_upd_r <= accept ? srcen : srcen_sh;
        end
        LINEUPD: begin
          a1_upd_r <= upda1_sh;
          a2_upd_r <= upda2_sh;
        end
        default: begin
          a1_upd_r <= 1'b0;
          a2_upd_r <= 1'b0;
        end
      endcase
    end
  end

  // An abort must cancel the pointer load in the very cycle it arrives.
  assign bus.a1_upd = a1_upd_r && !stop;
  assign bus.a2_upd = a2_upd_r && !stop;

endmodule

// File: doc/blit_addr_seq.md
# blit_addr_seq

Blitter address sequencer. It drives the address unit's pointer-update controls and the memory request handshake through a two-level loop: an inner pixel loop and an outer line loop. For each pixel it runs an optional source read using the A2 pointer, then a destination write using the A1 pointer, then a pointer-increment cycle. At the end of each line it runs a step cycle that applies the line step to A1 and/or A2.

## Interface
Parameters:
- CNT_W, default 16, width of the inner and outer loop counters.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetl  in  1  asynchronous, active-low reset.
- go  in  1  start pulse; sampled only in IDLE.
- inner_cnt  in  CNT_W  pixels per line; latched on an accepted go.
- outer_cnt  in  CNT_W  line count; latched on an accepted go.
- srcen  in  1  per-pixel source read enable; latched on go.
- upda1  in  1  apply A1 step at end of line; latched on go.
- upda2  in  1  apply A2 step at end of line; latched on go.
- stop  in  1  synchronous abort request.
- mem_ack  in  1  memory has accepted the current request.
- mem_req  out  1  memory cycle request.
- gena2  out  1  1 = address from A2 (source read), 0 = A1 (destination write).
- addbsel  out  2  add operand select: 00 = pixel increment (addx), 01 = line step, others unused.
- a1_upd  out  1  one-cycle strobe: load A1 pointer from adder.
- a2_upd  out  1  one-cycle strobe: load A2 pointer from adder.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- inner_rem  out  CNT_W  pixels remaining in the current line.
- outer_rem  out  CNT_W  lines remaining.

## Operation
States are IDLE, SREAD, DWRITE, PIXUPD, LINEUPD and DONE.

- **IDLE**
  - On go: latch inner_cnt, outer_cnt, srcen, upda1, upda2 into shadow registers; load inner_rem and outer_rem.
  - If inner_cnt==0 or outer_cnt==0, go to DONE with no memory cycles.
  - Otherwise go to SREAD if srcen, else DWRITE.
- **SREAD**
  - Outputs: mem_req=1, gena2=1.
  - Holds until mem_ack, then goes to DWRITE.
- **DWRITE**
  - Outputs: mem_req=1, gena2=0.
  - Holds until mem_ack, then goes to PIXUPD.
- **PIXUPD** (one cycle)
  - Outputs: addbsel=00, a1_upd=1, a2_upd=srcen.
  - inner_rem decrements by 1.
  - If inner_rem was 1, go to LINEUPD; otherwise start the next pixel (SREAD or DWRITE).
- **LINEUPD** (one cycle)
  - Outputs: addbsel=01, a1_upd=upda1, a2_upd=upda2.
  - outer_rem decrements by 1; inner_rem reloads from the shadow inner count.
  - If outer_rem was 1, go to DONE; otherwise start the next pixel.
- **DONE** (one cycle)
  - Outputs: done=1.
  - Then returns to IDLE.

Rules that apply across states:
- Outputs not listed for a state are 0. mem_req and gena2 are registered state decodes, stable for the whole request.
- go outside IDLE is ignored. Changes to the latched inputs after go have no effect until the next run.
- stop, in any state other than IDLE or DONE, forces the next state to DONE.
  - It suppresses a1_upd and a2_upd in that cycle.
  - If it coincides with mem_ack, the access counts as complete but no pointer update follows.
  - Counters freeze at their current values.
- Counters are unsigned CNT_W bits. The decrement from 1 to 0 never wraps, because the loops exit at 1.

## Timing
- Reset (resetl=0): state=IDLE; mem_req, gena2, addbsel, a1_upd, a2_upd, busy, done = 0; inner_rem = outer_rem = 0; shadow registers = 0. Outputs update immediately, without waiting for a clock edge.
- Reset deassertion: takes effect on the next rising clk edge.
- go sampled at edge 0 means the first active state is present in cycle 1.
- Cycles per pixel with mem_ack tied high: 3 with srcen=1, 2 with srcen=0. Each mem_ack stall cycle adds 1.
- Each line adds 1 cycle for LINEUPD.
- Total run (ack tied high): N·M·(2+srcen) + M cycles, then done in the following cycle. Here N is inner_cnt and M is outer_cnt.
- Back-to-back runs: the earliest accepted go is in the cycle after done.

## Test plan
- **2×2 transfer, srcen=1, upda1=1, upda2=0, mem_ack=1.**
  - 4 pixels × 3 cycles + 2 LINEUPD cycles: done in cycle 15.
  - a1_upd pulses 6 times; a2_upd pulses 4 times, all with addbsel=00.
  - Exactly 8 mem_req cycles, alternating gena2 1/0.
- **inner_cnt=0, outer_cnt=5.** done in cycle 1; mem_req never asserted; busy high for 1 cycle.
- **inner_cnt=3, outer_cnt=1, srcen=0; mem_ack held low 4 cycles on the second write.** DWRITE holds mem_req=1 and gena2=0 for 5 cycles; done in cycle 12; inner_rem sequence 3,2,1,0 then reload 3.
- **go pulsed again while busy, with different counts.** Ignored; run completes with the original counts; outer_rem unaffected.
- **stop in the 2nd PIXUPD of a 4×4 run.**
  - No a1_upd in that cycle; done the next cycle, then IDLE.
  - inner_rem and outer_rem hold 3 and 4.
- **resetl asserted mid-DWRITE.** mem_req, busy and counters go to 0 immediately; after release, a new go runs normally.
